// File: rtl/serial_alu_sequencer_pkg.sv
// Shared ALU operation codes and sequencer state encoding for the serial ALU,
// its 1-bit slice and benches.
package serial_alu_sequencer_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic op_is_arith(input logic [3:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/serial_alu_sequencer_alu_1_bit.sv
// One-bit ALU slice: AND/OR/ADD/SUB/NOR on a single bit with carry in/out.
// SUB inverts b; the caller supplies CarryIn=1 on the LSB to complete two's complement.
module ALU_1_bit
  import serial_alu_sequencer_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       CarryIn,
  input  logic [3:0] ALUOp,
  output logic       Result,
  output logic       CarryOut
);

  logic b_eff;

  always_comb begin
    Result   = 1'b0;
    CarryOut = 1'b0;
    b_eff    = (ALUOp == ALU_SUB) ? ~b : b;
    case (ALUOp)
      ALU_AND: Result = a & b;
      ALU_OR:  Result = a | b;
      ALU_NOR: Result = ~(a | b);
      ALU_ADD,
      ALU_SUB: begin
        Result   = a ^ b_eff ^ CarryIn;
        CarryOut = (a & b_eff) | (a & CarryIn) | (b_eff & CarryIn);
      end
      default: begin
        Result   = 1'b0;
        CarryOut = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/serial_alu_sequencer.sv
// Word-level multi-cycle ALU: feeds one ALU_1_bit slice LSB-first for WIDTH
// cycles, then presents Result and Zero/CarryOut/Overflow with a Done pulse.
module serial_alu_sequencer
  import serial_alu_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [3:0]       ALUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             CarryOut,
  output logic             Overflow
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  function automatic logic op_supported(input logic [3:0] op);
    return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) ||
           (op == ALU_SUB) || (op == ALU_NOR);
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-2:0] res_sh_q, res_sh_d;
  logic [3:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             slice_res, slice_cout;
  logic             accept;
  logic [WIDTH-1:0] fin_word;

  ALU_1_bit u_slice (
    .a        (a_sh_q[0]),
    .b        (b_sh_q[0]),
    .CarryIn  (carry_q),
    .ALUOp    (op_q),
    .Result   (slice_res),
    .CarryOut (slice_cout)
  );

  // Bits collected so far plus the bit the slice is producing this cycle.
  assign fin_word = {slice_res, res_sh_q};

  // A request in the Done cycle is taken on the edge Done drops, giving one op per WIDTH+1 cycles.
  assign accept = Start && (state_q != S_RUN);

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    op_d     = op_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_RUN;
      end
      S_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = (WIDTH-1)'(fin_word >> 1);
        carry_d  = slice_cout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          // carry_q is the carry into the MSB here; slice_cout is the carry out of it.
          if (op_supported(op_q)) begin
            result_d = fin_word;
            zero_d   = ~|fin_word;
            cout_d   = op_is_arith(op_q) & slice_cout;
            ovf_d    = op_is_arith(op_q) & (carry_q ^ slice_cout);
          end else begin
            result_d = '0;
            zero_d   = 1'b1;
            cout_d   = 1'b0;
            ovf_d    = 1'b0;
          end
        end
      end
      S_DONE: begin
        state_d = accept ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      a_sh_d  = A;
      b_sh_d  = B;
      op_d    = ALUOp;
      carry_d = (ALUOp == ALU_SUB);
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign Busy     = (state_q != S_IDLE);
  assign Done     = (state_q == S_DONE);
  assign Result   = result_q;
  assign Zero     = zero_q;
  assign CarryOut = cout_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Self-checking bench for serial_alu_sequencer: directed vector table, random
// ops against an arithmetic reference model, and handshake/reset sequences.
module tb_serial_alu_sequencer;
  import serial_alu_sequencer_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         Start;
  logic [3:0]   ALUOp;
  logic [W-1:0] A, B;
  logic         Busy, Done, Zero, CarryOut, Overflow;
  logic [W-1:0] Result;

  int errors = 0;
  int checks = 0;

  serial_alu_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Start    (Start),
    .ALUOp    (ALUOp),
    .A        (A),
    .B        (B),
    .Busy     (Busy),
    .Done     (Done),
    .Result   (Result),
    .Zero     (Zero),
    .CarryOut (CarryOut),
    .Overflow (Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         co;
    logic         ov;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: word-level arithmetic, carry = no-borrow for SUB.
  task automatic ref_model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] res, output logic z, output logic co, output logic ov);
    logic [W:0] s;
    res = '0; co = 1'b0; ov = 1'b0;
    case (op)
      4'b0000: res = a & b;
      4'b0001: res = a | b;
      4'b1100: res = ~(a | b);
      4'b0010: begin
        s = {1'b0, a} + {1'b0, b};
        res = s[W-1:0]; co = s[W];
        ov = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
      end
      4'b0110: begin
        s = {1'b0, a} + {1'b0, ~b} + 1;
        res = s[W-1:0]; co = s[W];
        ov = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
      end
      default: res = '0;
    endcase
    z = (res == 0);
  endtask

  task automatic start_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    Start = 1'b1; ALUOp = op; A = a; B = b;
    tick();
    Start = 1'b0;
    A = $urandom; B = $urandom; ALUOp = 4'($urandom_range(0, 15));
  endtask

  // Ticks until Done, bounded; Done must appear exactly W edges after acceptance.
  task automatic wait_done(input string name);
    int n = 0;
    while (!Done && n < W + 5) begin
      check({name, "_busy_run"}, Busy, 1'b1);
      tick();
      n++;
    end
    check({name, "_latency"}, n, W);
  endtask

  task automatic check_out(input string name, input logic [W-1:0] res, input logic z,
                           input logic co, input logic ov);
    check({name, "_done"}, Done, 1'b1);
    check({name, "_result"}, Result, res);
    check({name, "_zero"}, Zero, z);
    check({name, "_carry"}, CarryOut, co);
    check({name, "_ovf"}, Overflow, ov);
  endtask

  vec_t vecs[6];

  initial begin
    logic [W-1:0] er;
    logic ez, eco, eov;
    logic [3:0] op;
    logic [W-1:0] ra, rb;
    int dones;

    rst_n = 1'b0; Start = 1'b0; ALUOp = '0; A = '0; B = '0;
    vecs[0] = '{4'b0010, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{4'b0110, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{4'b0111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b1, 1'b0, 1'b0};

    #12;
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_result", Result, 0);
    check("rst_zero", Zero, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done($sformatf("vec%0d", i));
      check_out($sformatf("vec%0d", i), vecs[i].res, vecs[i].z, vecs[i].co, vecs[i].ov);
      tick();
      check($sformatf("vec%0d_done_drop", i), Done, 1'b0);
      check($sformatf("vec%0d_busy_drop", i), Busy, 1'b0);
      check($sformatf("vec%0d_hold", i), Result, vecs[i].res);
    end

    // Back-to-back logic ops, each Start presented in the Done cycle.
    start_op(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
    wait_done("b2b_and");
    check_out("b2b_and", 32'hF000_F000, 1'b0, 1'b0, 1'b0);
    start_op(ALU_OR, 32'hF0F0_F0F0, 32'hFF00_FF00);
    check("b2b_or_busy", Busy, 1'b1);
    check("b2b_or_nodone", Done, 1'b0);
    check("b2b_or_hold", Result, 32'hF000_F000);
    wait_done("b2b_or");
    check_out("b2b_or", 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);
    start_op(ALU_NOR, 32'hF0F0_F0F0, 32'hFF00_FF00);
    wait_done("b2b_nor");
    check_out("b2b_nor", 32'h000F_000F, 1'b0, 1'b0, 1'b0);
    tick();

    // Start during RUN must be ignored.
    start_op(ALU_ADD, 32'h0000_0010, 32'h0000_0020);
    repeat (5) tick();
    Start = 1'b1; ALUOp = ALU_SUB; A = 32'h0000_0100; B = 32'h0000_0001;
    tick();
    Start = 1'b0;
    dones = 0;
    for (int k = 0; k < W + 5 && !Done; k++) tick();
    check_out("ignore_start", 32'h0000_0030, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < W + 5; k++) begin
      tick();
      if (Done) dones++;
    end
    check("ignore_start_single_done", dones, 0);

    // Reset mid-RUN aborts without a Done.
    start_op(ALU_ADD, 32'h0000_0007, 32'h0000_0009);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check("abort_busy", Busy, 1'b0);
    check("abort_done", Done, 1'b0);
    check("abort_result", Result, 0);
    check("abort_flags", {Zero, CarryOut, Overflow}, 3'b000);
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < W + 5; k++) begin
      tick();
      if (Done || Busy) dones++;
    end
    check("abort_no_done", dones, 0);
    start_op(ALU_ADD, 32'h0000_0001, 32'h0000_0001);
    wait_done("post_rst");
    check_out("post_rst", 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    tick();

    // Random ops against the reference model.
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 5))
        0: op = ALU_AND;
        1: op = ALU_OR;
        2: op = ALU_ADD;
        3: op = ALU_SUB;
        4: op = ALU_NOR;
        default: op = 4'($urandom_range(0, 15));
      endcase
      ra = $urandom; rb = $urandom;
      if (n % 6 == 0) rb = ra;
      if (n % 8 == 1) ra = 32'h7FFF_FFFF;
      if (n % 8 == 2) ra = 32'h8000_0000;
      ref_model(op, ra, rb, er, ez, eco, eov);
      start_op(op, ra, rb);
      wait_done($sformatf("rnd%0d", n));
      check_out($sformatf("rnd%0d_op%0h", n, op), er, ez, eco, eov);
      if (n % 2 == 0) tick();
    end
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
